// File: rtl/wdog_ctrl.sv
// Watchdog supervisor: IDLE->RUN->WARN->BITE countdown; optional early-pet window via WDOG_WINDOW_EN.
// Latency: registered outputs, state moves on the clk edge after the cause; no backpressure, arm/pet sampled every cycle.
module wdog_ctrl #(
    parameter int unsigned BITE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        arm,
    input  logic        pet,
    input  logic [31:0] cfg_timeout,
    input  logic [31:0] cfg_grace,
    input  logic [31:0] cfg_window,
    output logic        warn,
    output logic        bite,
    output logic [1:0]  state,
    output logic        early,
    output logic [7:0]  bite_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WARN = 2'd2,
        BITE = 2'd3
    } st_t;

    st_t         st_q, st_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] grc_q, grc_d;
    logic [7:0]  bcnt_q, bcnt_d;
    logic        go_bite;
    logic        pet_early;

`ifdef WDOG_WINDOW_EN
    logic [31:0] win_q;
    logic        early_q;

    // A pet while the countdown is still above the window is treated as runaway software.
    assign pet_early = (cnt_q > win_q);

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            win_q   <= '0;
            early_q <= 1'b0;
        end else if (st_q == IDLE && arm) begin
            win_q   <= cfg_window;
            early_q <= 1'b0;
        end else if (st_q == RUN && arm && pet && pet_early) begin
            early_q <= 1'b1;
        end
    end

    assign early = early_q;
`else
    logic unused_window;
    assign unused_window = ^cfg_window;
    assign pet_early     = 1'b0;
    assign early         = 1'b0;
`endif

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            tmo_q  <= '0;
            grc_q  <= '0;
            bcnt_q <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            tmo_q  <= tmo_d;
            grc_q  <= grc_d;
            bcnt_q <= bcnt_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        grc_d   = grc_q;
        bcnt_d  = bcnt_q;
        go_bite = 1'b0;
        case (st_q)
            IDLE: begin
                cnt_d = '0;
                if (arm) begin
                    // Zero periods are clamped to one so the countdown always terminates.
                    tmo_d = (cfg_timeout == 32'd0) ? 32'd1 : cfg_timeout;
                    grc_d = (cfg_grace == 32'd0) ? 32'd1 : cfg_grace;
                    cnt_d = tmo_d;
                    st_d  = RUN;
                end
            end
            RUN: begin
                if (!arm) begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end else if (pet) begin
                    if (pet_early) go_bite = 1'b1;
                    else           cnt_d   = tmo_q;
                end else if (cnt_q == 32'd1) begin
                    st_d  = WARN;
                    cnt_d = grc_q;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            WARN: begin
                if (!arm) begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end else if (pet) begin
                    st_d  = RUN;
                    cnt_d = tmo_q;
                end else if (cnt_q == 32'd1) begin
                    go_bite = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            BITE: begin
                // Counter doubles as the bite-length timer; arm and pet are deliberately ignored.
                if (cnt_q == 32'd1) begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                st_d  = IDLE;
                cnt_d = '0;
            end
        endcase
        if (go_bite) begin
            st_d  = BITE;
            cnt_d = 32'(BITE_CYCLES);
            if (bcnt_q != 8'hFF) bcnt_d = bcnt_q + 8'd1;
        end
    end

    assign state    = st_q;
    assign warn     = (st_q == WARN);
    assign bite     = (st_q == BITE);
    assign bite_cnt = bcnt_q;

endmodule

// File: tb/tb_wdog_ctrl.sv
// Directed bench for wdog_ctrl with a deadline-based reference model compared every cycle.
module tb_wdog_ctrl;

    localparam int BC = 4;
`ifdef WDOG_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        arm = 1'b0;
    logic        pet = 1'b0;
    logic [31:0] cfg_timeout = 32'd0;
    logic [31:0] cfg_grace   = 32'd0;
    logic [31:0] cfg_window  = 32'd0;
    logic        warn, bite, early;
    logic [1:0]  state;
    logic [7:0]  bite_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wdog_ctrl #(.BITE_CYCLES(BC)) dut (
        .clk(clk), .Rst(Rst), .arm(arm), .pet(pet),
        .cfg_timeout(cfg_timeout), .cfg_grace(cfg_grace), .cfg_window(cfg_window),
        .warn(warn), .bite(bite), .state(state), .early(early), .bite_cnt(bite_cnt)
    );

    // Reference model: each phase ends at an absolute edge number (deadline).
    longint cyc_n = 0;
    longint m_dl  = 0;
    longint m_T = 0, m_G = 0, m_W = 0;
    int     m_st = 0;
    int     m_cnt = 0;
    bit     m_early = 1'b0;

    task automatic m_enter_bite();
        m_st = 3;
        m_dl = cyc_n + BC;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
    endtask

    always @(posedge clk or posedge Rst) begin
        if (Rst) begin
            m_st = 0; m_T = 0; m_G = 0; m_W = 0; m_cnt = 0; m_early = 1'b0;
        end else begin
            cyc_n = cyc_n + 1;
            case (m_st)
                0: if (arm) begin
                    m_T = (cfg_timeout == 0) ? 1 : longint'(cfg_timeout);
                    m_G = (cfg_grace == 0) ? 1 : longint'(cfg_grace);
                    m_W = longint'(cfg_window);
                    m_early = 1'b0;
                    m_st = 1;
                    m_dl = cyc_n + m_T;
                end
                1: if (!arm) m_st = 0;
                   else if (pet) begin
                       // remaining count before this edge is deadline - edge + 1
                       if (WIN && (m_dl - cyc_n + 1) > m_W) begin
                           m_early = 1'b1;
                           m_enter_bite();
                       end else m_dl = cyc_n + m_T;
                   end else if (cyc_n == m_dl) begin
                       m_st = 2;
                       m_dl = cyc_n + m_G;
                   end
                2: if (!arm) m_st = 0;
                   else if (pet) begin
                       m_st = 1;
                       m_dl = cyc_n + m_T;
                   end else if (cyc_n == m_dl) m_enter_bite();
                default: if (cyc_n == m_dl) m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [12:0] act, exp;
        act = {state, warn, bite, early, bite_cnt};
        exp = {2'(m_st), m_st == 2, m_st == 3, m_early, 8'(m_cnt)};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t got st/warn/bite/early/cnt=%0d/%0b/%0b/%0b/%0d want %0d/%0b/%0b/%0b/%0d",
                     $time, act[12:11], act[10], act[9], act[8], act[7:0],
                     exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_pet();
        pet = 1'b1;
        @(negedge clk);
        pet = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        cfg_window = 32'hFFFF_FFFF;
        cyc(3);
        chk("rst_state", 32'(state), 0);
        chk("rst_bite_cnt", 32'(bite_cnt), 0);
        chk("rst_warn_bite", 32'({warn, bite, early}), 0);

        // Free-running expiry: T=10, G=5
        Rst = 1'b0; cfg_timeout = 32'd10; cfg_grace = 32'd5; arm = 1'b1;
        cyc(1);  chk("run_entry", 32'(state), 1);
        cyc(9);  chk("no_warn_t9", 32'(warn), 0);
        cyc(1);  chk("warn_t10", 32'(warn), 1);
        cyc(4);  chk("warn_t14", 32'(warn), 1);
        cyc(1);  chk("bite_t15", 32'(bite), 1);
                 chk("bite_cnt_1", 32'(bite_cnt), 1);
        cyc(3);  chk("bite_t18", 32'(bite), 1);
        cyc(1);  chk("idle_t19", 32'(state), 0);
        cyc(1);  chk("rearm_t20", 32'(state), 1);

        // Regular service every 8 cycles
        for (int i = 0; i < 12; i++) begin
            cyc(7);
            do_pet();
        end
        chk("pet8_state", 32'(state), 1);
        chk("pet8_bite_cnt", 32'(bite_cnt), 1);

        // Pet on the last RUN count, then on the last WARN count
        cyc(9);  do_pet();
        chk("pet_last_run", 32'(state), 1);
        cyc(9);  chk("run_before_warn", 32'(state), 1);
        cyc(1);  chk("warn_entry", 32'(state), 2);
        cyc(4);  do_pet();
        chk("pet_last_warn", 32'(state), 1);
        chk("pet_last_warn_cnt", 32'(bite_cnt), 1);

        // Timeout port change mid-RUN must not affect reloads
        cfg_timeout = 32'd3;
        cyc(2);  do_pet();
        cyc(9);  chk("latched_t10_run", 32'(state), 1);
        cyc(1);  chk("latched_t10_warn", 32'(state), 2);
        arm = 1'b0;
        cyc(1);  chk("disarm_idle", 32'(state), 0);
                 chk("disarm_warn", 32'(warn), 0);
                 chk("disarm_cnt", 32'(bite_cnt), 1);
        arm = 1'b1;
        cyc(1);  chk("rearm_t3", 32'(state), 1);
        cyc(2);  chk("t3_run", 32'(state), 1);
        cyc(1);  chk("t3_warn", 32'(state), 2);
        arm = 1'b0;
        cyc(1);

        // Window: T=20, W=5
        cfg_timeout = 32'd20; cfg_window = 32'd5; arm = 1'b1;
        cyc(1);  chk("win_run", 32'(state), 1);
        cyc(8);  do_pet();
        if (WIN) begin
            chk("early_bite", 32'(state), 3);
            chk("early_flag", 32'(early), 1);
            chk("early_cnt", 32'(bite_cnt), 2);
            cyc(4);  chk("early_idle_flag", 32'(early), 1);
            cyc(1);  chk("early_rerun", 32'(state), 1);
                     chk("early_cleared", 32'(early), 0);
        end else begin
            chk("nowin_state", 32'(state), 1);
            chk("nowin_early", 32'(early), 0);
            chk("nowin_cnt", 32'(bite_cnt), 1);
        end
        cyc(15); chk("pre_pet5", 32'(state), 1);
        do_pet();
        chk("pet5_state", 32'(state), 1);
        cyc(19); chk("reload20_run", 32'(state), 1);
        cyc(1);  chk("reload20_warn", 32'(state), 2);

        // Reset during BITE
        cyc(5);  chk("bite_before_rst", 32'(bite), 1);
        #2 Rst = 1'b1;
        #1 chk("rst_mid_bite", 32'(bite), 0);
           chk("rst_mid_state", 32'(state), 0);
           chk("rst_mid_cnt", 32'(bite_cnt), 0);
        cyc(2);
        cfg_timeout = 32'd0; cfg_grace = 32'd0;
        Rst = 1'b0;
        chk("rst_release_idle", 32'(state), 0);
        cyc(1);  chk("first_edge_run", 32'(state), 1);

        // Repeated forced bites (7 cycles each) saturate the counter
        cyc(2200);
        chk("bite_cnt_sat", 32'(bite_cnt), 255);
        #2 Rst = 1'b1;
        #1 chk("rst_sat_cnt", 32'(bite_cnt), 0);
           chk("rst_sat_state", 32'(state), 0);
        cyc(1);
        Rst = 1'b0; arm = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wdog_ctrl.md
WDOG_CTRL -- requirements
Module: wdog_ctrl

Interface
REQ-001 SHALL have parameter BITE_CYCLES, default 16: cycles the bite output is held high; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port arm, input, 1 bit: level; 1 enables supervision, 0 disarms.
REQ-005 SHALL have port pet, input, 1 bit: single-cycle service strobe from software.
REQ-006 SHALL have port cfg_timeout, input, 32 bits: cycles from arm or pet to warning.
REQ-007 SHALL have port cfg_grace, input, 32 bits: cycles from warning to bite.
REQ-008 SHALL have port cfg_window, input, 32 bits: earliest-pet threshold, used only when windowing is compiled in.
REQ-009 SHALL have port warn, output, 1 bit: warning level, high in WARN state only.
REQ-010 SHALL have port bite, output, 1 bit: system-reset request, high in BITE state only.
REQ-011 SHALL have port state, output, 2 bits: IDLE=0, RUN=1, WARN=2, BITE=3.
REQ-012 SHALL have port early, output, 1 bit: sticky early-pet flag.
REQ-013 SHALL have port bite_cnt, output, 8 bits: number of bites since reset, saturating.

Function
REQ-014 SHALL latch cfg_timeout, cfg_grace and cfg_window into internal registers on the IDLE->RUN transition; later port changes have no effect until the next arm.
REQ-015 SHALL treat a latched timeout or grace of 0 as 1.
REQ-016 IDLE: counter held at 0; arm=1 SHALL move to RUN next cycle with counter loaded to the latched timeout.
REQ-017 RUN: counter SHALL decrement by 1 per cycle; pet SHALL reload it to the latched timeout; counter==1 without pet SHALL move to WARN with counter loaded to the latched grace.
REQ-018 Timing: warn SHALL rise exactly timeout cycles after the first RUN cycle when no pet occurs.
REQ-019 WARN: pet SHALL return to RUN with counter reloaded to timeout and warn low the next cycle; counter==1 without pet SHALL move to BITE.
REQ-020 Pet and expiry in the same cycle: pet SHALL win in both RUN and WARN.
REQ-021 BITE: bite high for exactly BITE_CYCLES cycles, then IDLE regardless of arm; pet and arm SHALL be ignored in BITE.
REQ-022 Entry to BITE SHALL increment bite_cnt by 1, saturating at 255.
REQ-023 arm=0 in RUN or WARN SHALL move to IDLE next cycle, with warn cleared and no bite.
REQ-024 After BITE->IDLE with arm still high, RUN SHALL re-enter on the following cycle (re-arm).
REQ-025 early SHALL clear on the IDLE->RUN transition and otherwise be set only per REQ-029.

Reset
REQ-026 While Rst=1 SHALL force state=IDLE, warn=0, bite=0, early=0, bite_cnt=0, and counter and latched configuration registers to 0.
REQ-027 Rst asserted mid-BITE SHALL terminate bite immediately (asynchronously).
REQ-028 The first state change after Rst falls SHALL occur on the next rising clk edge.

Configuration
REQ-029 With macro WDOG_WINDOW_EN defined: a pet in RUN while counter > latched cfg_window SHALL move to BITE (no reload) and set early; a pet with counter <= window SHALL behave per REQ-017.
REQ-030 Without WDOG_WINDOW_EN: cfg_window SHALL be ignored, early SHALL be constant 0, and pets are accepted at any counter value.

Verification
REQ-031 Bench SHALL cover: timeout=10, grace=5, BITE_CYCLES=4, arm held, no pet -> warn rises 10 cycles after RUN entry, bite high 4 cycles after 5 WARN cycles, bite_cnt=1, then re-RUN.
REQ-032 Bench SHALL cover: timeout=10, pet every 8 cycles for 100 cycles -> warn and bite never assert, state stays RUN.
REQ-033 Bench SHALL cover: pet on the exact cycle counter==1 in RUN and in WARN -> no transition to WARN and no transition to BITE, respectively.
REQ-034 Bench SHALL cover: arm dropped in WARN -> IDLE next cycle, warn=0, bite_cnt unchanged; cfg_timeout changed mid-RUN -> no effect until re-arm.
REQ-035 Bench SHALL cover (WDOG_WINDOW_EN defined): timeout=20, window=5, pet at counter=12 -> BITE and early=1; pet at counter=5 -> reload to 20.
REQ-036 Bench SHALL cover: Rst pulsed during BITE, and 300 forced bites -> outputs return to reset values immediately; bite_cnt saturates at 255.
